csi_rx_packet_handler: RTL and testbench
========================================

CSI_RX_PACKET_HANDLER -- requirements
Module: csi_rx_packet_handler

Interface
REQ-001 SHALL have parameter DT_FILTER, default 6'h2B, long-packet data type forwarded as payload (RAW10).
REQ-002 SHALL have port CLK  input  1  single clock for all logic.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ENABLE  input  1  block enable.
REQ-005 SHALL have port DIN  input  32  lane-merged word, byte 0 in [7:0].
REQ-006 SHALL have port DIN_VALID  input  1  DIN qualifier; high for a contiguous HS burst, low ends the burst.
REQ-007 SHALL have port PAYLOAD  output  32  long-packet payload word, feeds the 10-bit unpacker DIN.
REQ-008 SHALL have port PAYLOAD_VALID  output  1  PAYLOAD qualifier, feeds unpacker DIN_VALID.
REQ-009 SHALL have port PAYLOAD_LAST  output  1  marks final payload word of a packet.
REQ-010 SHALL have port FRAME_START, FRAME_END, LINE_START, LINE_END  output  1 each  one-cycle short-packet pulses.
REQ-011 SHALL have port VC  output  2  virtual channel of last accepted header.
REQ-012 SHALL have port DATA_TYPE  output  6  data type of last accepted header.
REQ-013 SHALL have port WORD_COUNT  output  16  WC field (or short-packet data) of last accepted header.
REQ-014 SHALL have port LINE_COUNT  output  16  forwarded long packets since last frame start.
REQ-015 SHALL have port TRUNC_ERR  output  1  one-cycle pulse when a burst ends before payload completes.

Function
REQ-016 SHALL decode header from first valid word of a burst: DI=DIN[7:0] (VC=[7:6], DT=[5:0]), WC=DIN[23:8], ECC=DIN[31:24] ignored (no correction).
REQ-017 SHALL implement FSM states WAIT_HDR, PAYLOAD, DRAIN.
REQ-018 WAIT_HDR: on DIN_VALID, latch VC/DATA_TYPE/WORD_COUNT; DT<=0x0F -> short packet, go DRAIN; DT==DT_FILTER and WC>0 -> PAYLOAD with remaining=WC; otherwise -> DRAIN.
REQ-019 Short DT 0x00/0x01/0x02/0x03 SHALL pulse FRAME_START/FRAME_END/LINE_START/LINE_END respectively one cycle after the header word; other short DTs produce no pulse.
REQ-020 PAYLOAD: each valid word SHALL appear on PAYLOAD with PAYLOAD_VALID=1 exactly one cycle later; remaining decrements by 4, saturating at 0.
REQ-021 Word with remaining<=4 SHALL assert PAYLOAD_LAST, increment LINE_COUNT (16-bit wrap), go DRAIN; unused high bytes passed unmodified.
REQ-022 Payload word count SHALL be ceil(WC/4); CRC and trailer bytes never forwarded.
REQ-023 DRAIN: ignore words until DIN_VALID low, then WAIT_HDR on the next cycle.
REQ-024 DIN_VALID low in WAIT_HDR: no action.
REQ-025 DIN_VALID low in PAYLOAD (remaining>0): pulse TRUNC_ERR, no PAYLOAD_LAST, no LINE_COUNT increment, go WAIT_HDR.
REQ-026 FRAME_START SHALL clear LINE_COUNT to 0 in the same cycle the pulse is driven.
REQ-027 PAYLOAD_VALID SHALL be low on every cycle not carrying payload; the unpacker relies on low to reset its byte phase between packets.
REQ-028 ENABLE low SHALL force WAIT_HDR and drive PAYLOAD_VALID, PAYLOAD_LAST, all pulses and TRUNC_ERR to 0 on the next cycle; PAYLOAD, VC, DATA_TYPE, WORD_COUNT, LINE_COUNT hold.
REQ-029 Header word with DIN_VALID dropping the following cycle SHALL still be processed; a long filtered packet then yields TRUNC_ERR one cycle after entering PAYLOAD.

Reset
REQ-030 RST_N low SHALL asynchronously set FSM to WAIT_HDR, remaining to 0, and every output to 0.
REQ-031 Reset deassertion mid-burst SHALL treat the next valid word as a header; the burst tail is not recovered.

Verification
REQ-032 FS short word 32'h00_0005_00 -> FRAME_START=1 one cycle, WORD_COUNT=5, LINE_COUNT=0.
REQ-033 Long header DT=0x2B WC=20 plus 5 payload words plus CRC word -> 5 PAYLOAD_VALID cycles, PAYLOAD_LAST on 5th, LINE_COUNT +1, CRC not forwarded.
REQ-034 Long header DT=0x2B WC=10 -> 3 payload words, LAST on 3rd; DT=0x2A WC=10 -> no PAYLOAD_VALID, DRAIN until burst end.
REQ-035 WC=20 burst ending after 2 payload words -> TRUNC_ERR pulse, LINE_COUNT unchanged, next burst header decoded correctly.
REQ-036 ENABLE dropped mid-payload -> outputs quiet next cycle, FSM in WAIT_HDR; RST_N asserted mid-payload -> all outputs 0 immediately.

Source files
------------

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 receive packet handler: decodes packet headers from lane-merged words,
// forwards filtered long-packet payload and pulses frame/line sync events.
module csi_rx_packet_handler #(
  parameter logic [5:0] DT_FILTER = 6'h2B
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic [31:0] DIN,
  input  logic        DIN_VALID,
  output logic [31:0] PAYLOAD,
  output logic        PAYLOAD_VALID,
  output logic        PAYLOAD_LAST,
  output logic        FRAME_START,
  output logic        FRAME_END,
  output logic        LINE_START,
  output logic        LINE_END,
  output logic [1:0]  VC,
  output logic [5:0]  DATA_TYPE,
  output logic [15:0] WORD_COUNT,
  output logic [15:0] LINE_COUNT,
  output logic        TRUNC_ERR
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned WC_W   = 16;
  localparam int unsigned DT_W   = 6;
  localparam int unsigned VC_W   = 2;

  localparam logic [1:0] ST_WAIT_HDR = 2'd0;
  localparam logic [1:0] ST_PAYLOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  localparam logic [DT_W-1:0] DT_FS        = 6'h00;
  localparam logic [DT_W-1:0] DT_FE        = 6'h01;
  localparam logic [DT_W-1:0] DT_LS        = 6'h02;
  localparam logic [DT_W-1:0] DT_LE        = 6'h03;
  localparam logic [DT_W-1:0] DT_SHORT_MAX = 6'h0F;
  localparam logic [WC_W-1:0] BYTES_PER_WORD = 16'd4;

  logic [1:0]        state_q, state_d;
  logic [WC_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0] payload_d;
  logic              payload_valid_d, payload_last_d;
  logic              frame_start_d, frame_end_d, line_start_d, line_end_d;
  logic [VC_W-1:0]   vc_d;
  logic [DT_W-1:0]   data_type_d;
  logic [WC_W-1:0]   word_count_d, line_count_d;
  logic              trunc_err_d;

  logic [VC_W-1:0]   hdr_vc;
  logic [DT_W-1:0]   hdr_dt;
  logic [WC_W-1:0]   hdr_wc;

  assign hdr_vc = DIN[7:6];
  assign hdr_dt = DIN[5:0];
  assign hdr_wc = DIN[23:8];

  // Next-state and next-output logic; pulses and qualifiers default low.
  always_comb begin
    state_d         = state_q;
    remaining_d     = remaining_q;
    payload_d       = PAYLOAD;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    frame_start_d   = 1'b0;
    frame_end_d     = 1'b0;
    line_start_d    = 1'b0;
    line_end_d      = 1'b0;
    vc_d            = VC;
    data_type_d     = DATA_TYPE;
    word_count_d    = WORD_COUNT;
    line_count_d    = LINE_COUNT;
    trunc_err_d     = 1'b0;

    if (!ENABLE) begin
      state_d     = ST_WAIT_HDR;
      remaining_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_HDR: begin
          if (DIN_VALID) begin
            vc_d         = hdr_vc;
            data_type_d  = hdr_dt;
            word_count_d = hdr_wc;
            if (hdr_dt <= DT_SHORT_MAX) begin
              state_d = ST_DRAIN;
              case (hdr_dt)
                DT_FS: begin
                  frame_start_d = 1'b1;
                  line_count_d  = '0;
                end
                DT_FE:   frame_end_d  = 1'b1;
                DT_LS:   line_start_d = 1'b1;
                DT_LE:   line_end_d   = 1'b1;
                default: ;
              endcase
            end else if ((hdr_dt == DT_FILTER) && (hdr_wc != '0)) begin
              state_d     = ST_PAYLOAD;
              remaining_d = hdr_wc;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end

        ST_PAYLOAD: begin
          if (DIN_VALID) begin
            payload_d       = DIN;
            payload_valid_d = 1'b1;
            if (remaining_q <= BYTES_PER_WORD) begin
              payload_last_d = 1'b1;
              line_count_d   = LINE_COUNT + 16'd1;
              remaining_d    = '0;
              state_d        = ST_DRAIN;
            end else begin
              remaining_d = remaining_q - BYTES_PER_WORD;
            end
          end else begin
            // Burst ended before the announced byte count arrived.
            trunc_err_d = 1'b1;
            remaining_d = '0;
            state_d     = ST_WAIT_HDR;
          end
        end

        ST_DRAIN: begin
          if (!DIN_VALID) state_d = ST_WAIT_HDR;
        end

        default: begin
          state_d     = ST_WAIT_HDR;
          remaining_d = '0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= ST_WAIT_HDR;
      remaining_q   <= '0;
      PAYLOAD       <= '0;
      PAYLOAD_VALID <= 1'b0;
      PAYLOAD_LAST  <= 1'b0;
      FRAME_START   <= 1'b0;
      FRAME_END     <= 1'b0;
      LINE_START    <= 1'b0;
      LINE_END      <= 1'b0;
      VC            <= '0;
      DATA_TYPE     <= '0;
      WORD_COUNT    <= '0;
      LINE_COUNT    <= '0;
      TRUNC_ERR     <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      PAYLOAD       <= payload_d;
      PAYLOAD_VALID <= payload_valid_d;
      PAYLOAD_LAST  <= payload_last_d;
      FRAME_START   <= frame_start_d;
      FRAME_END     <= frame_end_d;
      LINE_START    <= line_start_d;
      LINE_END      <= line_end_d;
      VC            <= vc_d;
      DATA_TYPE     <= data_type_d;
      WORD_COUNT    <= word_count_d;
      LINE_COUNT    <= line_count_d;
      TRUNC_ERR     <= trunc_err_d;
    end
  end

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Bench for csi_rx_packet_handler: burst-level reference model over directed and
// random bursts, followed by directed enable and reset scenarios.
module tb_csi_rx_packet_handler;

  localparam logic [5:0] DT_FILTER = 6'h2B;
  localparam int MAXC = 4096;

  logic        CLK = 1'b0;
  logic        RST_N, ENABLE, DIN_VALID;
  logic [31:0] DIN;
  logic [31:0] PAYLOAD;
  logic        PAYLOAD_VALID, PAYLOAD_LAST;
  logic        FRAME_START, FRAME_END, LINE_START, LINE_END;
  logic [1:0]  VC;
  logic [5:0]  DATA_TYPE;
  logic [15:0] WORD_COUNT, LINE_COUNT;
  logic        TRUNC_ERR;

  always #5 CLK = ~CLK;

  csi_rx_packet_handler #(.DT_FILTER(DT_FILTER)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .PAYLOAD(PAYLOAD), .PAYLOAD_VALID(PAYLOAD_VALID), .PAYLOAD_LAST(PAYLOAD_LAST),
    .FRAME_START(FRAME_START), .FRAME_END(FRAME_END), .LINE_START(LINE_START),
    .LINE_END(LINE_END), .VC(VC), .DATA_TYPE(DATA_TYPE), .WORD_COUNT(WORD_COUNT),
    .LINE_COUNT(LINE_COUNT), .TRUNC_ERR(TRUNC_ERR)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus schedule and the events each input cycle is expected to produce.
  logic [31:0] stim_din [MAXC];
  bit          stim_val [MAXC];
  bit          hdr_ev   [MAXC];
  logic [31:0] hdr_word [MAXC];
  bit          pl_ev    [MAXC];
  bit          last_ev  [MAXC];
  bit [3:0]    pulse_ev [MAXC];
  bit          trunc_ev [MAXC];
  int          ncyc = 0;

  function automatic logic [78:0] pack(input logic [31:0] p, input logic pv, input logic lst,
                                       input logic [3:0] pul, input logic [1:0] vc,
                                       input logic [5:0] dt, input logic [15:0] wc,
                                       input logic [15:0] lc, input logic tr);
    return {p, pv, lst, pul, vc, dt, wc, lc, tr};
  endfunction

  function automatic logic [78:0] observed();
    return pack(PAYLOAD, PAYLOAD_VALID, PAYLOAD_LAST,
                {LINE_END, LINE_START, FRAME_END, FRAME_START},
                VC, DATA_TYPE, WORD_COUNT, LINE_COUNT, TRUNC_ERR);
  endfunction

  task automatic check(input string tag, input logic [78:0] exp);
    logic [78:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      stim_din[ncyc] = $urandom;
      stim_val[ncyc] = 1'b0;
      ncyc++;
    end
  endtask

  // Append a burst of n valid words (header first) followed by gap idle cycles.
  task automatic add_burst(input logic [5:0] dt, input logic [1:0] vc, input logic [15:0] wc,
                           input int n, input int gap);
    int t0, nw, fwd;
    logic [7:0] ecc;
    t0  = ncyc;
    ecc = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      stim_din[ncyc] = (i == 0) ? {ecc, wc, vc, dt} : $urandom;
      stim_val[ncyc] = 1'b1;
      ncyc++;
    end
    hdr_ev[t0]   = 1'b1;
    hdr_word[t0] = stim_din[t0];
    if (dt <= 6'h0F) begin
      if (dt < 6'd4) pulse_ev[t0][dt[1:0]] = 1'b1;
    end else if (dt == DT_FILTER && wc != 16'd0) begin
      nw  = (int'(wc) + 3) / 4;
      fwd = (n - 1 < nw) ? n - 1 : nw;
      for (int i = 0; i < fwd; i++) pl_ev[t0 + 1 + i] = 1'b1;
      if (n - 1 >= nw) last_ev[t0 + nw] = 1'b1;
      else             trunc_ev[t0 + n] = 1'b1;
    end
    add_idle(gap);
  endtask

  task automatic step(input logic [31:0] d, input logic v);
    DIN = d;
    DIN_VALID = v;
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] m_payload, w1, w2, w3, w4, w5;
  logic [1:0]  m_vc;
  logic [5:0]  m_dt;
  logic [15:0] m_wc, m_lc;

  initial begin
    int r, nw, n;
    logic [5:0]  dt;
    logic [15:0] wc;

    RST_N = 1'b0; ENABLE = 1'b1; DIN = '0; DIN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", '0);
    RST_N = 1'b1;

    // Directed bursts
    add_idle(2);
    add_burst(6'h00, 2'd0, 16'd5,  1, 2);
    add_burst(6'h02, 2'd0, 16'd0,  1, 1);
    add_burst(6'h2B, 2'd0, 16'd20, 6, 1);
    add_burst(6'h03, 2'd1, 16'd0,  2, 1);
    add_burst(6'h2B, 2'd1, 16'd10, 4, 1);
    add_burst(6'h2A, 2'd0, 16'd10, 4, 2);
    add_burst(6'h2B, 2'd2, 16'd20, 3, 1);
    add_burst(6'h01, 2'd3, 16'd7,  1, 1);
    add_burst(6'h2B, 2'd0, 16'd8,  1, 1);
    add_burst(6'h2B, 2'd0, 16'd0,  2, 1);
    add_burst(6'h07, 2'd2, 16'd33, 1, 1);
    add_burst(6'h00, 2'd1, 16'd1,  1, 1);

    // Random bursts
    while (ncyc < MAXC - 64) begin
      r  = $urandom_range(0, 9);
      wc = 16'($urandom_range(0, 40));
      if (r < 3) begin
        dt = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 15)) : 6'($urandom_range(0, 3));
        n  = $urandom_range(1, 3);
      end else if (r < 8) begin
        dt = DT_FILTER;
        nw = (int'(wc) + 3) / 4;
        if (nw == 0)                          n = $urandom_range(1, 3);
        else if ($urandom_range(0, 4) == 0)   n = $urandom_range(1, nw);
        else                                  n = nw + 1 + $urandom_range(0, 2);
      end else begin
        dt = 6'($urandom_range(16, 63));
        n  = $urandom_range(1, 4);
      end
      add_burst(dt, 2'($urandom), wc, n, $urandom_range(1, 3));
    end

    // Play the schedule, advancing the model one consumed input at a time
    m_payload = '0; m_vc = '0; m_dt = '0; m_wc = '0; m_lc = '0;
    for (int c = 0; c < ncyc; c++) begin
      step(stim_din[c], stim_val[c]);
      if (hdr_ev[c]) begin
        m_vc = hdr_word[c][7:6];
        m_dt = hdr_word[c][5:0];
        m_wc = hdr_word[c][23:8];
      end
      if (pulse_ev[c][0]) m_lc = '0;
      if (pl_ev[c])       m_payload = stim_din[c];
      if (last_ev[c])     m_lc = m_lc + 16'd1;
      check($sformatf("stream_c%0d", c),
            pack(m_payload, pl_ev[c], last_ev[c], pulse_ev[c], m_vc, m_dt, m_wc, m_lc, trunc_ev[c]));
    end

    // ENABLE dropped mid-payload
    w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom; w5 = $urandom;
    step({8'h5A, 16'd20, 2'd1, 6'h2B}, 1'b1);
    check("en_hdr", pack(m_payload, 0, 0, 4'b0, 2'd1, 6'h2B, 16'd20, m_lc, 0));
    step(w1, 1'b1);
    check("en_pl1", pack(w1, 1, 0, 4'b0, 2'd1, 6'h2B, 16'd20, m_lc, 0));
    step(w2, 1'b1);
    check("en_pl2", pack(w2, 1, 0, 4'b0, 2'd1, 6'h2B, 16'd20, m_lc, 0));
    ENABLE = 1'b0;
    step(w3, 1'b1);
    check("en_low_quiet", pack(w2, 0, 0, 4'b0, 2'd1, 6'h2B, 16'd20, m_lc, 0));
    ENABLE = 1'b1;
    step({8'h00, 16'd7, 2'd2, 6'h01}, 1'b1);
    check("en_back_hdr", pack(w2, 0, 0, 4'b0010, 2'd2, 6'h01, 16'd7, m_lc, 0));
    step(32'h0, 1'b0);
    check("en_back_idle", pack(w2, 0, 0, 4'b0, 2'd2, 6'h01, 16'd7, m_lc, 0));

    // RST_N asserted mid-payload, then released mid-burst
    step({8'h11, 16'd12, 2'd0, 6'h2B}, 1'b1);
    check("rst_hdr", pack(w2, 0, 0, 4'b0, 2'd0, 6'h2B, 16'd12, m_lc, 0));
    step(w4, 1'b1);
    check("rst_pl1", pack(w4, 1, 0, 4'b0, 2'd0, 6'h2B, 16'd12, m_lc, 0));
    DIN = w5;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("rst_async", '0);
    @(negedge CLK);
    RST_N = 1'b1;
    step({8'h00, 16'd9, 2'd3, 6'h00}, 1'b1);
    check("rst_next_hdr", pack(32'h0, 0, 0, 4'b0001, 2'd3, 6'h00, 16'd9, 16'd0, 0));
    step(32'h0, 1'b0);
    check("rst_idle", pack(32'h0, 0, 0, 4'b0, 2'd3, 6'h00, 16'd9, 16'd0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
